// File: rtl/sc_pair_to_bin.sv
// sc_pair_to_bin: dual-channel stochastic-to-binary converter.
// Counts ones on two unipolar bitstreams over a window of 2^WIDTH-1 accepted
// samples and presents the two counts as registered operands A and B for a
// downstream ripple subtractor (D = A - B, whose borrow-out compares the streams).
//
// Latency: start -> COUNT in 1 cycle; final accepted sample -> out_valid in 1 cycle
//          (256 cycles start-to-result at WIDTH=8 with in_valid held high).
// Backpressure: samples are accepted only while in_ready (COUNT); results are
//          held in DONE until out_valid & out_ready. Samples outside COUNT are dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin one window (honoured only in IDLE)
//   xa, xb, in_valid    sample bits for channels A/B and their qualifier
//   in_ready            high in COUNT
//   A, B                registered ones-counts (minuend, subtrahend)
//   out_valid/out_ready result handshake
//   busy                high in COUNT
//   overrun             sticky result-overwrite flag (continuous mode only)
//
// Build option: define SC2B_CONTINUOUS_EN for back-to-back windows without
// start; an unconsumed result overwritten by the next window sets overrun.
// Without it the block is single-shot and overrun is tied to 0.

module sc_pair_to_bin #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             xa,
  input  logic             xb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Index of the last sample of a window: window length is 2^WIDTH-1, so the
  // sample counter (0-based) reads 2^WIDTH-2 when the final sample arrives.
  localparam logic [WIDTH-1:0] LAST_IDX = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ZERO     = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] smp_cnt_q, smp_cnt_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             last_smp;
  logic             handshake;
  logic [WIDTH-1:0] xa_ext;
  logic [WIDTH-1:0] xb_ext;
  logic [WIDTH-1:0] cnt_a_inc;
  logic [WIDTH-1:0] cnt_b_inc;

  assign accept    = (state_q == S_COUNT) & in_valid;
  assign last_smp  = accept & (smp_cnt_q == LAST_IDX);
  assign handshake = out_valid_q & out_ready;

  assign xa_ext    = {{(WIDTH-1){1'b0}}, xa};
  assign xb_ext    = {{(WIDTH-1){1'b0}}, xb};
  // Ones-counts including the sample on the bus this cycle; never exceed
  // 2^WIDTH-1 because a window holds at most that many samples.
  assign cnt_a_inc = cnt_a_q + xa_ext;
  assign cnt_b_inc = cnt_b_q + xb_ext;

`ifdef SC2B_CONTINUOUS_EN
  logic overrun_q, overrun_d;
`endif

  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
`ifdef SC2B_CONTINUOUS_EN
    overrun_d   = overrun_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COUNT;
          smp_cnt_d = ZERO;
          cnt_a_d   = ZERO;
          cnt_b_d   = ZERO;
        end
      end

      S_COUNT: begin
`ifdef SC2B_CONTINUOUS_EN
        // A result may still be pending from the previous window; it is
        // consumed here unless a new completion replaces it below.
        if (handshake) begin
          out_valid_d = 1'b0;
        end
`endif
        if (last_smp) begin
          a_d         = cnt_a_inc;
          b_d         = cnt_b_inc;
          out_valid_d = 1'b1;
          smp_cnt_d   = ZERO;
          cnt_a_d     = ZERO;
          cnt_b_d     = ZERO;
`ifdef SC2B_CONTINUOUS_EN
          // Overwriting a result nobody took this cycle is an overrun; a
          // simultaneous handshake means the old result was consumed.
          if (out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
          end
`else
          state_d     = S_DONE;
`endif
        end else if (accept) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
          cnt_a_d   = cnt_a_inc;
          cnt_b_d   = cnt_b_inc;
        end
      end

      S_DONE: begin
        // start is deliberately ignored here, even on the handshake cycle.
        if (handshake) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      smp_cnt_q   <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SC2B_CONTINUOUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign in_ready  = (state_q == S_COUNT);
  assign busy      = (state_q == S_COUNT);
  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sc_pair_to_bin.sv
module tb_sc_pair_to_bin;

  localparam int WIDTH = 8;
  localparam int NWIN  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             xa;
  logic             xb;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  sc_pair_to_bin #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .xa       (xa),
    .xb       (xb),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a window is 2^WIDTH-1 valid samples offered while the
  // block is counting; expected counts are plain sums of the offered bits.
  // pattern: 0 xa=1,xb=0; 1 alternating (xa starts 1, xb starts 0);
  //          2 xa=xb=1; 3 xa=0,xb=1; 4 random with per-mille probs pa/pb.
  // gap: percent of cycles with in_valid low. Returns counts and the number
  // of cycles from raising start to the cycle after the last sample.
  task automatic feed(input int pattern, input int gap, input int pa, input int pb,
                      input int nsamp, output int ea, output int eb, output int cyc);
    int n;
    ea = 0; eb = 0; n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (n < nsamp) begin
      in_valid = ($urandom_range(99) >= gap);
      case (pattern)
        0: begin xa = 1'b1; xb = 1'b0; end
        1: begin xa = (n % 2 == 0); xb = (n % 2 == 1); end
        2: begin xa = 1'b1; xb = 1'b1; end
        3: begin xa = 1'b0; xb = 1'b1; end
        default: begin
          xa = ($urandom_range(999) < pa);
          xb = ($urandom_range(999) < pb);
        end
      endcase
      if (in_valid) begin
        n++;
        ea += int'(xa);
        eb += int'(xb);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    xa = $urandom_range(1);
    xb = $urandom_range(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; xa = 0; xb = 0; in_valid = 0; out_ready = 0;
    #3;
    checks++;
    if ({A, B, out_valid, in_ready, busy, overrun} !== {16'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_values: A=%0d B=%0d ov=%b ir=%b busy=%b orun=%b, want all 0",
               A, B, out_valid, in_ready, busy, overrun);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_ratio();
    int ea, eb, cyc;
    start = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_to_count: in_ready=%b busy=%b, want 1 1", in_ready, busy);
    end
    start = 1'b0;
    // Block is already counting; feed's extra start pulse is ignored.
    feed(0, 0, 0, 0, NWIN, ea, eb, cyc);
    checks++;
    if (A !== 8'd255 || B !== 8'd0 || ea != 255 || eb != 0) begin
      errors++;
      $display("FAIL ratio_counts: A=%0d B=%0d, want 255 0", A, B);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ratio_done: out_valid=%b in_ready=%b busy=%b, want 1 0 0",
               out_valid, in_ready, busy);
    end
    checks++;
    if (A - B !== 8'd255 || A < B) begin
      errors++;
      $display("FAIL ratio_sub: D=%0d bout=%b, want 255 0", A - B, A < B);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ratio_handshake: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_alternating();
    int ea, eb, cyc;
    feed(1, 0, 0, 0, NWIN, ea, eb, cyc);
    checks++;
    if (A !== 8'd128 || B !== 8'd127 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL alternating: A=%0d B=%0d ov=%b, want 128 127 1", A, B, out_valid);
    end
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL min_latency: cycles=%0d, want 256", cyc);
    end
    checks++;
    if (A < B) begin
      errors++;
      $display("FAIL alternating_bout: bout=1, want 0");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_gaps();
    int ea, eb, cyc;
    feed(2, 50, 0, 0, NWIN, ea, eb, cyc);
    checks++;
    if (A !== 8'd255 || B !== 8'd255 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gaps: A=%0d B=%0d ov=%b, want 255 255 1", A, B, out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int ea, eb, cyc;
    int bad;
    feed(4, 20, 700, 300, NWIN, ea, eb, cyc);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = $urandom_range(1);
      in_valid = 1'b1;
      xa = 1'b1;
      xb = 1'b1;
      tick();
      checks++;
      if (A !== ea[WIDTH-1:0] || B !== eb[WIDTH-1:0] || out_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL hold_%0d: A=%0d B=%0d ov=%b busy=%b, want %0d %0d 1 0",
                   i, A, B, out_valid, busy, ea, eb);
      end
    end
    in_valid = 1'b0;
    // Handshake with start asserted in the same cycle: start must be ignored.
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL handshake_to_idle: ov=%b busy=%b ir=%b, want 0 0 0",
               out_valid, busy, in_ready);
    end
    // Result persists through IDLE; out_ready in IDLE has no effect.
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checks++;
    if (A !== ea[WIDTH-1:0] || B !== eb[WIDTH-1:0] || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_retain: A=%0d B=%0d ov=%b busy=%b, want %0d %0d 0 0",
               A, B, out_valid, busy, ea, eb);
    end
  endtask

  task automatic test_reset_mid_window();
    int ea, eb, cyc;
    feed(2, 0, 0, 0, 100, ea, eb, cyc);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({A, B, out_valid, in_ready, busy, overrun} !== {16'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid: A=%0d B=%0d ov=%b ir=%b busy=%b, want all 0",
               A, B, out_valid, in_ready, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    feed(3, 10, 0, 0, NWIN, ea, eb, cyc);
    checks++;
    if (A !== 8'd0 || B !== 8'd255 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_window: A=%0d B=%0d ov=%b, want 0 255 1", A, B, out_valid);
    end
    checks++;
    if (!(A < B)) begin
      errors++;
      $display("FAIL after_reset_bout: bout=0, want 1");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random_windows();
    int ea, eb, cyc, pa, pb, gap;
    for (int w = 0; w < 6; w++) begin
      pa  = $urandom_range(1000);
      pb  = $urandom_range(1000);
      gap = (w % 2 == 0) ? 0 : $urandom_range(60);
      feed(4, gap, pa, pb, NWIN, ea, eb, cyc);
      checks++;
      if (A !== ea[WIDTH-1:0] || B !== eb[WIDTH-1:0] || out_valid !== 1'b1 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: A=%0d B=%0d ov=%b orun=%b, want %0d %0d 1 0",
                 w, A, B, out_valid, overrun, ea, eb);
      end
      if (gap == 0) begin
        checks++;
        if (cyc != 256) begin
          errors++;
          $display("FAIL random_latency_%0d: cycles=%0d, want 256", w, cyc);
        end
      end
      // Random consume delay before the handshake.
      for (int d = $urandom_range(3); d > 0; d--) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_hs_%0d: out_valid=%b, want 0", w, out_valid);
      end
    end
  endtask

`ifdef SC2B_CONTINUOUS_EN
  task automatic test_continuous();
    int ea1, eb1, ea2, eb2, cyc;
    feed(4, 0, 600, 400, NWIN, ea1, eb1, cyc);
    checks++;
    if (A !== ea1[WIDTH-1:0] || B !== eb1[WIDTH-1:0] || out_valid !== 1'b1 ||
        in_ready !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL cont_first: A=%0d B=%0d ov=%b ir=%b orun=%b, want %0d %0d 1 1 0",
               A, B, out_valid, in_ready, overrun, ea1, eb1);
    end
    // The block is still counting; the pulse of start inside feed is ignored.
    feed(4, 0, 200, 900, NWIN, ea2, eb2, cyc);
    checks++;
    if (A !== ea2[WIDTH-1:0] || B !== eb2[WIDTH-1:0] || out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL cont_overrun: A=%0d B=%0d ov=%b orun=%b, want %0d %0d 1 1",
               A, B, out_valid, overrun, ea2, eb2);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SC2B_CONTINUOUS_EN
    test_continuous();
`else
    test_ratio();
    test_alternating();
    test_gaps();
    test_backpressure();
    test_reset_mid_window();
    test_random_windows();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_pair_to_bin.md
# sc_pair_to_bin

Dual-channel stochastic-to-binary converter: counts the ones in two parallel unipolar bitstreams over a fixed window of 2^WIDTH−1 accepted samples. It presents the two counts as registered WIDTH-bit operands A and B with a valid/ready handshake. It sits directly upstream of the 8-bit gate-level ripple subtractor (D = A − B, BOUT), supplying its A and B inputs. The subtractor's borrow-out then indicates which stream had the higher probability.

## Interface
Parameters:
- WIDTH, 8: count/operand width; window length is 2^WIDTH−1 samples (255 at default), so a full count never overflows.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one conversion window; honoured only in IDLE.
- xa  in  1  stochastic bit, channel A.
- xb  in  1  stochastic bit, channel B.
- in_valid  in  1  xa/xb carry a sample this cycle.
- in_ready  out  1  block accepts samples; high only in COUNT.
- A  out  WIDTH  registered ones-count of xa (subtractor minuend).
- B  out  WIDTH  registered ones-count of xb (subtractor subtrahend).
- out_valid  out  1  A/B hold a completed result.
- out_ready  in  1  downstream consumes result.
- busy  out  1  high in COUNT.
- overrun  out  1  sticky: unconsumed result overwritten (continuous mode only; constant 0 otherwise).

## Operation
- State machine: IDLE, COUNT, DONE.
- IDLE → COUNT on start=1. Sample counter and both ones-counters clear to 0 on entry.
- COUNT: a sample is accepted when in_valid & in_ready.
  - Each accepted sample increments the sample counter, adds xa to cntA, and adds xb to cntB.
  - On the 2^WIDTH−1-th accepted sample, A/B load cntA/cntB including that sample, and the block goes to DONE.
- DONE: out_valid=1, and A/B are held stable. When out_valid & out_ready, go to IDLE.
- start is ignored in COUNT and DONE. Samples presented outside COUNT are dropped, not buffered.
- Counts are unsigned. cntA, cntB ≤ 2^WIDTH−1 by construction, so no saturation logic is needed.
- A and B retain their last result through IDLE and COUNT. Downstream qualifies them with out_valid only.

## Timing
- Reset values: state IDLE; A=0; B=0; out_valid=0; in_ready=0; busy=0; overrun=0; all counters 0.
- start sampled high in cycle t → in_ready=1, busy=1 from cycle t+1.
- Final sample accepted in cycle t → out_valid=1, in_ready=0, and A/B valid in cycle t+1.
- Minimum latency from start to out_valid is 256 cycles at WIDTH=8 (one idle-to-count cycle plus 255 samples), with in_valid held high.
- Handshake completing in cycle t → out_valid=0 in t+1.
- start in the same cycle as the handshake is ignored; start must be reasserted in IDLE.
- out_ready has no effect when out_valid=0.
- Reset asserted mid-window or in DONE aborts immediately to the reset values. No partial result is emitted.

## Configuration
- SC2B_CONTINUOUS_EN
  - Defined: after the final sample, the block loads A/B, asserts out_valid, and stays in COUNT with counters cleared. The next window starts the cycle after the final sample and start is not required. out_valid clears on handshake.
  - Defined, overrun: if a window completes while out_valid=1 and no handshake happens that cycle, A/B are overwritten and overrun sets. overrun stays set until rst_n.
  - Defined, simultaneous events: a handshake in the same cycle as a completion keeps out_valid=1 with the new data and does not set overrun.
  - Not defined: single-shot behaviour as above, and overrun is tied to 0.

## Test plan
- Ratio check: start; 255 samples with xa=1, xb=0 → A=255, B=0, out_valid one cycle after the last sample; subtractor gives D=255, BOUT=0.
- Alternating bits: xa toggles 1,0,… starting at 1; xb toggles starting at 0 → A=128, B=127.
- Input gaps: in_valid randomly low ~50% of cycles, xa=xb=1 → A=B=255 exactly; non-valid cycles not counted.
- Backpressure: result ready, out_ready low 20 cycles → A/B/out_valid stable. start pulses in DONE ignored. Handshake → IDLE next cycle.
- Reset mid-window: rst_n low after 100 samples → all outputs at reset values. New start with xb=1 only → A=0, B=255.
- Continuous mode (macro defined): in_valid=1, out_ready=0 → first result out_valid; second completion sets overrun=1 and A/B show the second window's counts.
